// File: rtl/frq_glide_pkg.sv
// Shared constants for the frequency glide engine: voice count, address map, FSM encoding.
package frq_glide_pkg;

  localparam int NVOICE = 32;

  typedef enum logic [1:0] {
    BANK_TGT  = 2'b00,
    BANK_RATE = 2'b01,
    BANK_CUR  = 2'b10,
    BANK_REG  = 2'b11
  } bank_e;

  localparam logic [7:0] ADDR_CTRL = 8'h60;
  localparam logic [7:0] ADDR_DONE = 8'h61;
  localparam logic [7:0] ADDR_STAT = 8'h62;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CALC = 2'd2,
    WR   = 2'd3
  } state_e;

  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/bram_256x32.sv
// 256x32 block RAM, byte write enables, registered read port (1 cycle).
// Same-address read during write returns the merged new word (write-first).
module bram_256x32
  import frq_glide_pkg::*;
(
  input  logic        clk_i,
  input  logic [3:0]  we_i,
  input  logic [7:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [7:0]  raddr_i,
  output logic [31:0] rdata_o
);

  logic [31:0] mem_q [256];
  logic [31:0] mask;
  logic [31:0] wmerged;

  assign mask    = byte_mask(we_i);
  assign wmerged = (mem_q[waddr_i] & ~mask) | (wdata_i & mask);

  always_ff @(posedge clk_i) begin
    if (|we_i) mem_q[waddr_i] <= wmerged;
    rdata_o <= (|we_i && (raddr_i == waddr_i)) ? wmerged : mem_q[raddr_i];
  end

endmodule

// File: rtl/frq_glide_step.sv
// One glide step toward the target, clamped so it never overshoots or wraps.
// Purely combinational.
module glide_step (
  input  logic [31:0] cur_i,
  input  logic [31:0] tgt_i,
  input  logic [31:0] rate_i,
  output logic [31:0] nxt_o,
  output logic        done_o
);

  always_comb begin
    nxt_o = cur_i;
    if (cur_i < tgt_i) begin
      nxt_o = ((tgt_i - cur_i) <= rate_i) ? tgt_i : cur_i + rate_i;
    end else if (cur_i > tgt_i) begin
      nxt_o = ((cur_i - tgt_i) <= rate_i) ? tgt_i : cur_i - rate_i;
    end
  end

  assign done_o = (nxt_o == tgt_i);

endmodule

// File: rtl/frq_glide.sv
// Per-voice frequency glide: every TICK_DIV clocks sweep 32 voices (RD/CALC/WR), writing each
// new frequency to the sound generator; CPU current writes are forwarded one cycle later.
module frq_glide
  import frq_glide_pkg::*;
#(
  parameter int TICK_DIV = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic [3:0]  we,
  input  logic [7:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        snd_cs,
  output logic [3:0]  snd_we,
  output logic [7:0]  snd_addr,
  output logic [31:0] snd_din
);

  localparam int CW = $clog2(TICK_DIV);

  state_e       state_q, state_d;
  logic [4:0]   voice_q, voice_d;
  logic [CW-1:0] tick_cnt_q;
  logic         en_q, ovr_q;
  logic [31:0]  done_q, dout_q, nxt_q;
  logic         ndone_q, fwd_q;
  logic [4:0]   fwd_v_q;

  logic        tick, cpu_wr, cpu_rd, tgt_wr, rate_wr, cur_wr, eng_wr;
  logic [4:0]  cpu_v;
  logic [31:0] tgt_rdata, rate_rdata, cur_rdata, step_nxt;
  logic        step_done;

  assign tick    = (tick_cnt_q == CW'(TICK_DIV - 1));
  assign cpu_wr  = cs & (|we);
  assign cpu_rd  = cs & ~(|we);
  assign cpu_v   = addr[4:0];
  assign tgt_wr  = cpu_wr & ~addr[7] & (addr[6:5] == BANK_TGT);
  assign rate_wr = cpu_wr & ~addr[7] & (addr[6:5] == BANK_RATE);
  assign cur_wr  = cpu_wr & ~addr[7] & (addr[6:5] == BANK_CUR);

  // A CPU write cycle doubles as the read cycle for the engine's voice, so a write every
  // third cycle still lets the sweep progress. The current RAM read port is lent to the
  // CPU for forwarding; if that targets another voice, the engine re-reads next cycle.
  always_comb begin
    state_d = state_q;
    voice_d = voice_q;
    eng_wr  = 1'b0;
    case (state_q)
      IDLE: if (tick && en_q) begin
        state_d = RD;
        voice_d = '0;
      end
      RD:   state_d = CALC;
      CALC: state_d = WR;
      WR: begin
        eng_wr = 1'b1;
        if (voice_q == 5'(NVOICE - 1)) begin
          state_d = IDLE;
        end else begin
          state_d = RD;
          voice_d = voice_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && cpu_wr) begin
      eng_wr  = 1'b0;
      voice_d = voice_q;
      state_d = (cur_wr && cpu_v != voice_q) ? RD : CALC;
    end
  end

  bram_256x32 u_tgt_ram (
    .clk_i(clk), .we_i(tgt_wr ? we : 4'h0), .waddr_i({3'b000, cpu_v}), .wdata_i(din),
    .raddr_i({3'b000, voice_q}), .rdata_o(tgt_rdata)
  );

  bram_256x32 u_rate_ram (
    .clk_i(clk), .we_i(rate_wr ? we : 4'h0), .waddr_i({3'b000, cpu_v}), .wdata_i(din),
    .raddr_i({3'b000, voice_q}), .rdata_o(rate_rdata)
  );

  bram_256x32 u_cur_ram (
    .clk_i(clk),
    .we_i(cur_wr ? we : (eng_wr ? 4'hF : 4'h0)),
    .waddr_i({3'b000, cur_wr ? cpu_v : voice_q}),
    .wdata_i(cur_wr ? din : nxt_q),
    .raddr_i({3'b000, cur_wr ? cpu_v : voice_q}),
    .rdata_o(cur_rdata)
  );

  glide_step u_step (
    .cur_i(cur_rdata), .tgt_i(tgt_rdata), .rate_i(rate_rdata),
    .nxt_o(step_nxt), .done_o(step_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      voice_q    <= '0;
      tick_cnt_q <= '0;
      en_q       <= 1'b0;
      ovr_q      <= 1'b0;
      done_q     <= 32'hFFFF_FFFF;
      dout_q     <= '0;
      nxt_q      <= '0;
      ndone_q    <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_v_q    <= '0;
    end else begin
      state_q    <= state_d;
      voice_q    <= voice_d;
      tick_cnt_q <= tick ? '0 : tick_cnt_q + CW'(1);
      fwd_q      <= cur_wr;
      fwd_v_q    <= cpu_v;
      if (state_q == CALC) begin
        nxt_q   <= step_nxt;
        ndone_q <= step_done;
      end
      if (cpu_wr && addr == ADDR_CTRL && we[0]) en_q <= din[0];
      if (tick && state_q != IDLE)                           ovr_q <= 1'b1;
      else if (cpu_wr && addr == ADDR_STAT && we[0] && din[0]) ovr_q <= 1'b0;
      if (eng_wr)              done_q[voice_q] <= ndone_q;
      if (tgt_wr || cur_wr)    done_q[cpu_v]   <= 1'b0;
      if (cpu_rd) begin
        case (addr)
          ADDR_CTRL: dout_q <= {31'b0, en_q};
          ADDR_DONE: dout_q <= done_q;
          ADDR_STAT: dout_q <= {31'b0, ovr_q};
          default:   dout_q <= '0;
        endcase
      end
    end
  end

  assign dout     = dout_q;
  assign snd_cs   = fwd_q | eng_wr;
  assign snd_we   = snd_cs ? 4'hF : 4'h0;
  assign snd_addr = fwd_q ? {3'b000, fwd_v_q} : (eng_wr ? {3'b000, voice_q} : 8'h00);
  assign snd_din  = fwd_q ? cur_rdata : (eng_wr ? nxt_q : 32'h0);

endmodule

// File: tb/tb_frq_glide.sv
// Directed bench for frq_glide with TICK_DIV=128; snd_* strobes are logged per voice.
module tb_frq_glide;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b0;
  logic [3:0]  we = 4'h0;
  logic [7:0]  addr = 8'h00;
  logic [31:0] din = 32'h0;
  logic [31:0] dout;
  logic        snd_cs;
  logic [3:0]  snd_we;
  logic [7:0]  snd_addr;
  logic [31:0] snd_din;

  always #5 clk = ~clk;

  frq_glide #(.TICK_DIV(128)) dut (
    .clk(clk), .reset(reset), .cs(cs), .we(we), .addr(addr), .din(din), .dout(dout),
    .snd_cs(snd_cs), .snd_we(snd_we), .snd_addr(snd_addr), .snd_din(snd_din)
  );

  int n_vec = 0;
  int n_bad = 0;
  int unsigned snd_cnt [32] = '{default: 0};
  logic [31:0] snd_last [32] = '{default: 32'h0};
  int bad_strobe = 0;

  always @(negedge clk) begin
    if (!reset && snd_cs) begin
      snd_cnt[snd_addr[4:0]] += 1;
      snd_last[snd_addr[4:0]] = snd_din;
      if (snd_we != 4'hF || snd_addr[7:5] != 3'b000) bad_strobe += 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    cs = 1'b1; we = be; addr = a; din = d;
    @(negedge clk);
    cs = 1'b0; we = 4'h0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; we = 4'h0; addr = a;
    @(negedge clk);
    cs = 1'b0;
    d = dout;
  endtask

  // Waits for the next strobe of voice v; returns just after the following rising edge.
  task automatic wait_v(input int v, input int budget, input string tag);
    int unsigned base;
    base = snd_cnt[v];
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (snd_cnt[v] != base) break;
    end
    chk(tag, snd_cnt[v] - base, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic chk_once(input string tag, input int unsigned base [32]);
    logic ok;
    ok = 1'b1;
    for (int v = 0; v < 32; v++) if (snd_cnt[v] - base[v] != 1) ok = 1'b0;
    chk(tag, {31'b0, ok}, 32'd1);
  endtask

  function automatic int unsigned total_cnt();
    int unsigned s;
    s = 0;
    for (int v = 0; v < 32; v++) s += snd_cnt[v];
    return s;
  endfunction

  logic [31:0] rdv;
  int unsigned base [32];
  int unsigned tot;

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // reset state
    chk("rst_dout", dout, 32'h0);
    chk("rst_snd_cs", {31'b0, snd_cs}, 32'h0);
    chk("rst_snd_we", {28'b0, snd_we}, 32'h0);
    chk("rst_snd_addr", {24'b0, snd_addr}, 32'h0);
    chk("rst_snd_din", snd_din, 32'h0);
    rd(8'h60, rdv); chk("rst_ctrl", rdv, 32'h0);
    rd(8'h61, rdv); chk("rst_done", rdv, 32'hFFFF_FFFF);
    rd(8'h62, rdv); chk("rst_stat", rdv, 32'h0);

    // forward of a CPU write to current[5], full word then low two bytes
    wr(8'h45, 32'hDEAD_BEEF, 4'hF);
    chk("fwd_cs", {31'b0, snd_cs}, 32'h1);
    chk("fwd_we", {28'b0, snd_we}, 32'hF);
    chk("fwd_addr", {24'b0, snd_addr}, 32'h05);
    chk("fwd_din", snd_din, 32'hDEAD_BEEF);
    rd(8'h61, rdv); chk("fwd_done5", rdv, 32'hFFFF_FFDF);
    wr(8'h45, 32'h1122_3344, 4'b0011);
    chk("fwd_merge", snd_din, 32'hDEAD_3344);
    rd(8'h45, rdv); chk("ram_read_zero", rdv, 32'h0);

    // voice 1: downward clamp to 0; voice 2: rate 0 holds; others glide 1000->1300 by 100
    for (int v = 0; v < 32; v++) begin
      logic [7:0] vv;
      vv = 8'(v);
      if (v == 1) begin
        wr(8'h00 | vv, 32'h0, 4'hF); wr(8'h20 | vv, 32'h100, 4'hF); wr(8'h40 | vv, 32'h50, 4'hF);
      end else if (v == 2) begin
        wr(8'h00 | vv, 32'd900, 4'hF); wr(8'h20 | vv, 32'd0, 4'hF); wr(8'h40 | vv, 32'd500, 4'hF);
      end else begin
        wr(8'h00 | vv, 32'd1300, 4'hF); wr(8'h20 | vv, 32'd100, 4'hF); wr(8'h40 | vv, 32'd1000, 4'hF);
      end
    end
    rd(8'h61, rdv); chk("setup_done", rdv, 32'h0);

    base = snd_cnt;
    wr(8'h60, 32'h1, 4'h1);
    wait_v(31, 400, "sweep1_end");
    chk_once("sweep1_once", base);
    chk("s1_v0", snd_last[0], 32'd1100);
    chk("s1_v1_nowrap", snd_last[1], 32'h0);
    chk("s1_v2_hold", snd_last[2], 32'd500);
    chk("s1_v31", snd_last[31], 32'd1100);
    rd(8'h61, rdv); chk("s1_done", rdv, 32'h0000_0002);

    base = snd_cnt;
    wait_v(31, 400, "sweep2_end");
    chk_once("sweep2_once", base);
    chk("s2_v0", snd_last[0], 32'd1200);
    chk("s2_v30", snd_last[30], 32'd1200);

    wait_v(31, 400, "sweep3_end");
    chk("s3_v0", snd_last[0], 32'd1300);
    rd(8'h61, rdv); chk("s3_done", rdv, 32'hFFFF_FFFB);

    // CPU write every third cycle across a whole sweep
    base = snd_cnt;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (snd_cnt[31] != base[31]) break;
      cs = (i % 3 == 0); we = 4'hF; addr = 8'h61; din = 32'h0;
    end
    cs = 1'b0; we = 4'h0;
    chk_once("s4_hammer_once", base);
    chk("s4_v0", snd_last[0], 32'd1300);
    chk("s4_v1", snd_last[1], 32'h0);
    chk("s4_v2", snd_last[2], 32'd500);
    chk("s4_v17", snd_last[17], 32'd1300);

    // continuous writes stall the sweep so a tick is dropped; last write clears enable
    @(posedge clk); #1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      cs = 1'b1; we = 4'hF; addr = 8'h61; din = 32'h0;
    end
    @(negedge clk);
    addr = 8'h60; din = 32'h0;
    @(negedge clk);
    cs = 1'b0; we = 4'h0;
    rd(8'h62, rdv); chk("overrun_set", rdv, 32'h1);
    wait_v(31, 300, "drain_end");
    tot = total_cnt();
    repeat (300) @(negedge clk);
    chk("no_new_sweep", total_cnt() - tot, 32'd0);
    wr(8'h62, 32'h1, 4'h1);
    rd(8'h62, rdv); chk("overrun_clr", rdv, 32'h0);

    // reset while voice 10 is in CALC
    wr(8'h60, 32'h1, 4'h1);
    wait_v(9, 400, "pre_reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst2_snd_cs", {31'b0, snd_cs}, 32'h0);
    tot = total_cnt();
    repeat (300) @(negedge clk);
    chk("rst2_quiet", total_cnt() - tot, 32'd0);
    rd(8'h61, rdv); chk("rst2_done", rdv, 32'hFFFF_FFFF);
    rd(8'h60, rdv); chk("rst2_ctrl", rdv, 32'h0);

    // RAM survives reset: re-enabled sweep reproduces settled values
    wr(8'h60, 32'h1, 4'h1);
    wait_v(31, 400, "post_reset_sweep");
    chk("pr_v10", snd_last[10], 32'd1300);
    chk("pr_v2", snd_last[2], 32'd500);
    chk("strobe_shape", bad_strobe, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
